// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its queue.
package mips_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_DATA_W  = 32;
  localparam int unsigned FETCH_Q_DEPTH = 3;
  localparam int unsigned FETCH_Q_PTR_W = $clog2(FETCH_Q_DEPTH);
  localparam int unsigned FETCH_Q_CNT_W = $clog2(FETCH_Q_DEPTH + 1);

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage : mips_fetch_pkg

// File: rtl/imem_fetch_ctrl_fetch_q.sv
// fetch_q: small synchronous FIFO of fetched words; flush wins over push and pop,
// head entry is visible combinationally.
module fetch_q
  import mips_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [FETCH_Q_CNT_W-1:0] count,
  output logic                     empty
);

  fetch_entry_t             mem [FETCH_Q_DEPTH];
  logic [FETCH_Q_PTR_W-1:0] wr_ptr;
  logic [FETCH_Q_PTR_W-1:0] rd_ptr;
  logic                     full;
  logic                     do_push;
  logic                     do_pop;

  function automatic logic [FETCH_Q_PTR_W-1:0] bump(input logic [FETCH_Q_PTR_W-1:0] p);
    return (p == FETCH_Q_PTR_W'(FETCH_Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FETCH_Q_CNT_W'(FETCH_Q_DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and count are, so the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : fetch_q

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the PC, sequences a 1-cycle synchronous instruction ROM and hands
// words to decode over valid/ready. Optional FETCH_STATS_EN adds a saturating pop counter.
module imem_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned       DATA_W    = FETCH_DATA_W,
  parameter int unsigned       ROM_DEPTH = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_t             state_q, state_d;
  logic [ADDR_W-1:0]        pc_q;
  logic [ADDR_W-1:0]        rom_addr_q;
  logic [ADDR_W-1:0]        v1_pc_q;
  logic                     v0_q, v1_q;
  logic                     pop, can_run, issue;
  logic [ADDR_W-1:0]        target;
  logic [FETCH_Q_CNT_W:0]   occ;
  logic [FETCH_Q_CNT_W-1:0] q_count;
  logic                     q_empty;
  fetch_entry_t             q_head, q_push_entry;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(ROM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)          state_d = RUN;
      RUN:     if (halt)        state_d = HALTED;
      HALTED:  if (en && !halt) state_d = RUN;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Occupancy counts every word already owned by this block: queued, in the ROM, or on rom_data.
  assign pop      = instr_valid && instr_ready;
  assign occ      = {1'b0, q_count} + (FETCH_Q_CNT_W + 1)'(v0_q) + (FETCH_Q_CNT_W + 1)'(v1_q)
                  - (FETCH_Q_CNT_W + 1)'(pop);
  assign can_run  = (state_q == RUN) && !halt;
  assign issue    = can_run && !redirect && (occ < (FETCH_Q_CNT_W + 1)'(FETCH_Q_DEPTH));
  assign target   = redirect_pc % ADDR_W'(ROM_DEPTH);

  // A redirect in RUN presents its target on rom_addr at the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rom_addr_q <= RESET_PC;
      v1_pc_q    <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
    end else if (redirect) begin
      v1_q <= 1'b0;
      if (can_run) begin
        rom_addr_q <= target;
        pc_q       <= next_pc(target);
        v0_q       <= 1'b1;
      end else begin
        pc_q <= target;
        v0_q <= 1'b0;
      end
    end else begin
      v1_q    <= v0_q;
      v1_pc_q <= rom_addr_q;
      v0_q    <= issue;
      if (issue) begin
        rom_addr_q <= pc_q;
        pc_q       <= next_pc(pc_q);
      end
    end
  end

  assign q_push_entry = '{pc: FETCH_ADDR_W'(v1_pc_q), instr: FETCH_DATA_W'(rom_data)};

  fetch_q u_fetch_q (
    .clk        (clk),
    .rst        (rst),
    .push       (v1_q),
    .push_entry (q_push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (q_head),
    .count      (q_count),
    .empty      (q_empty)
  );

  assign rom_addr    = rom_addr_q;
  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? DATA_W'(q_head.instr) : DATA_W'(NOP_INSTR);
  assign instr_pc    = instr_valid ? ADDR_W'(q_head.pc) : '0;
  assign busy        = (state_q == RUN) || v0_q || v1_q || !q_empty;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst)                            fetch_count_q <= '0;
    else if (pop && fetch_count_q != '1) fetch_count_q <= fetch_count_q + 1'b1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule : imem_fetch_ctrl
